// File: rtl/uart_tx_sb_ctrl.sv
// uart_tx_sb_ctrl
//   System-bus UART transmitter peripheral. It holds the memory-mapped
//   register file and the transmit engine: a fractional baud generator, a
//   frame FSM and a shift register.
//
//   Register map (byte offsets):
//     0x00 data      R/W [7:0]   a write while idle starts a frame
//     0x04 done      RO  [0]     only when UART_TX_IRQ_EN is defined
//     0x08 busy      RO  [0]
//     0x0C baudrate  R/W [16:0]  accepted range 1..131071
//     0x10 parity_en R/W [0]     accepted values 0/1
//     0x14 stopbit   R/W [1:0]   accepted values 1/2
//     0x24 reset     WO          writing 32'h1 resets the block synchronously
//
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     addr_i                 byte offset within the peripheral
//     req_i, write_enable_i  bus request qualifier and direction (1 = write)
//     write_data_i           write data
//     read_data_o            registered read data, one-cycle latency
//     tx_o                   UART serial line, idle high
//     interrupt_request_o    (UART_TX_IRQ_EN) frame-done flag
//     interrupt_return_i     (UART_TX_IRQ_EN) clears the done flag
//
//   Optional feature macro: UART_TX_IRQ_EN.
//
//   Bus handshake: there is no ready/valid pair. A transfer happens in every
//   cycle where req_i is high; write_enable_i selects the direction. Writes
//   take effect on that edge (or are dropped while busy, except soft reset);
//   reads of mapped offsets load read_data_o on that edge, otherwise
//   read_data_o holds.
module uart_tx_sb_ctrl #(
  parameter int CLK_FREQ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
`ifdef UART_TX_IRQ_EN
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
`endif
  output logic        tx_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  data_q;
  logic [7:0]  shift_q;
  logic [16:0] baud_q;
  logic        par_en_q;
  logic [1:0]  stop_q;
  logic        par_en_snap;
  logic [1:0]  stop_snap;
  logic [2:0]  bit_cnt;
  logic [1:0]  stop_cnt;
  logic [31:0] acc;
  logic [31:0] rd_q;
  logic [32:0] acc_sum;
  logic [31:0] acc_nxt;
  logic        tick;
  logic        busy;
  logic        wr, rd, wr_ok, soft_rst, start_frame, stop_last, frame_end;
  logic [31:0] rd_mux;
  logic        rd_hit;
`ifdef UART_TX_IRQ_EN
  logic        done_q;
`endif

  assign busy        = (state != IDLE);
  assign wr          = req_i & write_enable_i;
  assign rd          = req_i & ~write_enable_i;
  // Soft reset is honoured even mid-frame; every other write needs idle.
  assign soft_rst    = wr & (addr_i == 32'h24) & (write_data_i == 32'h1);
  assign wr_ok       = wr & ~busy;
  assign start_frame = wr_ok & (addr_i == 32'h0);
  assign read_data_o = rd_q;

  // Fractional baud generator: the accumulator wraps modulo CLK_FREQ, so the
  // average bit period is CLK_FREQ/baudrate cycles.
  always_comb begin
    acc_sum = {1'b0, acc} + {16'd0, baud_q};
    tick    = busy && (acc_sum >= 33'(CLK_FREQ));
    acc_nxt = tick ? 32'(acc_sum - 33'(CLK_FREQ)) : acc_sum[31:0];
  end

  // Stop phase counts ticks from 0; the last one is stopbit-1.
  assign stop_last = (stop_cnt == (stop_snap - 2'd1));
  assign frame_end = (state == STOP) && tick && stop_last;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_frame) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bit_cnt == 3'd7) state_nxt = par_en_snap ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick && stop_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line driver; decoded from state so an async reset forces idle-high at once.
  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      PARITY:  tx_o = ^data_q;
      default: tx_o = 1'b1;
    endcase
  end

  // Read decode
  always_comb begin
    rd_mux = 32'd0;
    rd_hit = 1'b1;
    case (addr_i)
      32'h00:  rd_mux = {24'd0, data_q};
`ifdef UART_TX_IRQ_EN
      32'h04:  rd_mux = {31'd0, done_q};
`endif
      32'h08:  rd_mux = {31'd0, busy};
      32'h0C:  rd_mux = {15'd0, baud_q};
      32'h10:  rd_mux = {31'd0, par_en_q};
      32'h14:  rd_mux = {30'd0, stop_q};
      default: rd_hit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       state <= IDLE;
    else if (soft_rst) state <= IDLE;
    else               state <= state_nxt;
  end

  // Registers, datapath and read port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q      <= 8'd0;
      shift_q     <= 8'd0;
      baud_q      <= 17'd9600;
      par_en_q    <= 1'b0;
      stop_q      <= 2'd1;
      par_en_snap <= 1'b0;
      stop_snap   <= 2'd1;
      bit_cnt     <= 3'd0;
      stop_cnt    <= 2'd0;
      acc         <= 32'd0;
      rd_q        <= 32'd0;
    end else if (soft_rst) begin
      data_q      <= 8'd0;
      shift_q     <= 8'd0;
      baud_q      <= 17'd9600;
      par_en_q    <= 1'b0;
      stop_q      <= 2'd1;
      par_en_snap <= 1'b0;
      stop_snap   <= 2'd1;
      bit_cnt     <= 3'd0;
      stop_cnt    <= 2'd0;
      acc         <= 32'd0;
      rd_q        <= 32'd0;
    end else begin
      if (wr_ok) begin
        case (addr_i)
          32'h00: data_q <= write_data_i[7:0];
          32'h0C: if (write_data_i != 32'd0 && write_data_i[31:17] == 15'd0)
                    baud_q <= write_data_i[16:0];
          32'h10: if (write_data_i[31:1] == 31'd0) par_en_q <= write_data_i[0];
          32'h14: if (write_data_i == 32'd1 || write_data_i == 32'd2)
                    stop_q <= write_data_i[1:0];
          default: ;
        endcase
      end

      if (start_frame) begin
        // Config is snapshotted so the running frame never sees a change.
        shift_q     <= write_data_i[7:0];
        par_en_snap <= par_en_q;
        stop_snap   <= stop_q;
        bit_cnt     <= 3'd0;
        stop_cnt    <= 2'd0;
        acc         <= 32'd0;
      end else if (busy) begin
        acc <= acc_nxt;
        if (state == DATA && tick) begin
          shift_q <= {1'b0, shift_q[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == STOP && tick) stop_cnt <= stop_cnt + 2'd1;
      end

      if (rd && rd_hit) rd_q <= rd_mux;
    end
  end

`ifdef UART_TX_IRQ_EN
  // Done flag: set as busy falls; set wins over a same-edge clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                            done_q <= 1'b0;
    else if (soft_rst)                                      done_q <= 1'b0;
    else if (frame_end)                                     done_q <= 1'b1;
    else if (interrupt_return_i || (rd && addr_i == 32'h08)) done_q <= 1'b0;
  end
  assign interrupt_request_o = done_q;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Bench for uart_tx_sb_ctrl with CLK_FREQ=16 so that baudrate=4 gives
// exactly 4 clocks per bit. Expected line levels (per cycle), read data and
// point samples are queued by the driver and consumed by one monitor.
module tb_uart_tx_sb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        req = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq_req;
  logic        irq_ret = 1'b0;
`endif

  uart_tx_sb_ctrl #(.CLK_FREQ(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .addr_i         (addr),
    .req_i          (req),
    .write_data_i   (wdata),
    .write_enable_i (we),
    .read_data_o    (rdata),
`ifdef UART_TX_IRQ_EN
    .interrupt_request_o (irq_req),
    .interrupt_return_i  (irq_ret),
`endif
    .tx_o           (tx)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [0:0]  tx_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] dir_exp_q[$];
  logic [31:0] dir_act_q[$];
  string       dir_tag_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          tx_cyc = 0;
  logic        rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= req & ~we;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [0:0]  e;
    logic [31:0] ed, ad, ea;
    string       t;
    if (tx_q.size() > 0) begin
      e = tx_q.pop_front();
      tx_cyc++;
      n_checks++;
      if (tx !== e) begin
        n_fail++;
        $display("FAIL tx_o line cycle %0d: got %b want %b", tx_cyc, tx, e);
      end
    end
    if (rd_seen) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_data_o: got %0d with no read expected", rdata);
      end else begin
        ed = exp_q.pop_front();
        ea = rd_addr_q.pop_front();
        if (rdata !== ed) begin
          n_fail++;
          $display("FAIL read 0x%02h: got %0d want %0d", ea, rdata, ed);
        end
      end
    end
    while (dir_exp_q.size() > 0) begin
      ed = dir_exp_q.pop_front();
      ad = dir_act_q.pop_front();
      t  = dir_tag_q.pop_front();
      n_checks++;
      if (ad !== ed) begin
        n_fail++;
        $display("FAIL %s: got %0d want %0d", t, ad, ed);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample(input string tag, input logic [31:0] act, input logic [31:0] exp);
    dir_tag_q.push_back(tag);
    dir_act_q.push_back(act);
    dir_exp_q.push_back(exp);
  endtask

  // One bus transfer; returns 1 time unit after the edge that sampled it.
  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(posedge clk);
    #1;
    addr = a; wdata = d; we = w; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_cycle(a, d, 1'b1);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    rd_addr_q.push_back(a);
    bus_cycle(a, 32'd0, 1'b0);
  endtask

  // Time-ordered line levels, oldest in bit n-1; each level lasts 4 clocks.
  task automatic push_levels(input logic [11:0] lv, input int n);
    for (int i = n - 1; i >= 0; i--)
      repeat (4) tx_q.push_back(lv[i]);
  endtask

  task automatic wait_tx_drain(input int limit);
    int n = 0;
    while (tx_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (tx_q.size() != 0) begin
      sample("tx_drain_timeout", 32'd0, 32'd1);
      tx_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    sample("reset_tx", {31'd0, tx}, 32'd1);
    sample("reset_rdata", rdata, 32'd0);
    #1 rst_n = 1'b1;
    repeat (8) tx_q.push_back(1'b1);

    // Reset values
    bus_read(32'h0C, 32'd9600);
`ifdef UART_TX_IRQ_EN
    bus_read(32'h04, 32'd0);
`else
    bus_read(32'h04, 32'd9600);   // unmapped: holds previous value
`endif
    bus_read(32'h10, 32'd0);
    bus_read(32'h14, 32'd1);
    bus_read(32'h08, 32'd0);
    bus_read(32'h00, 32'd0);

    // Frame 8'hA5, 8N1
    bus_write(32'h0C, 32'd4);
    bus_read(32'h0C, 32'd4);
    wait_tx_drain(100);
    bus_write(32'h00, 32'h0000_00A5);
    push_levels(12'b00_0101001011, 10);
    repeat (3) @(posedge clk);
    bus_read(32'h08, 32'd1);
    bus_write(32'h0C, 32'd100);    // dropped while busy
    bus_write(32'h00, 32'h55);     // dropped while busy
    bus_read(32'h0C, 32'd4);
    wait_tx_drain(200);
`ifdef UART_TX_IRQ_EN
    @(posedge clk); #1;
    sample("irq_after_frame", {31'd0, irq_req}, 32'd1);
    irq_ret = 1'b1;
    @(posedge clk); #1;
    irq_ret = 1'b0;
    sample("irq_after_return", {31'd0, irq_req}, 32'd0);
    bus_read(32'h04, 32'd0);
`endif
    bus_read(32'h08, 32'd0);
    bus_read(32'h00, 32'hA5);

    // Frame 8'h07 with even parity and two stop bits
    bus_write(32'h10, 32'd1);
    bus_write(32'h14, 32'd2);
    bus_read(32'h10, 32'd1);
    bus_read(32'h14, 32'd2);
    wait_tx_drain(100);
    bus_write(32'h00, 32'h07);
    push_levels(12'b011100000111, 12);
    wait_tx_drain(200);
    bus_read(32'h08, 32'd0);
    bus_read(32'h00, 32'h07);

    // Out-of-range and read-only writes while idle
    bus_write(32'h0C, 32'd0);
    bus_write(32'h0C, 32'h0002_0000);
    bus_write(32'h14, 32'd3);
    bus_write(32'h10, 32'd2);
    bus_write(32'h08, 32'd1);
    bus_read(32'h0C, 32'd4);
    bus_read(32'h14, 32'd2);
    bus_read(32'h10, 32'd1);
    bus_read(32'h08, 32'd0);

    // Asynchronous reset mid-frame (frame 8'h3C, bit 0 is 0)
    bus_read(32'h0C, 32'd4);
    bus_write(32'h00, 32'h3C);
    repeat (6) @(negedge clk);
    sample("tx_mid_frame_a", {31'd0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    sample("tx_async_reset", {31'd0, tx}, 32'd1);
    sample("rdata_async_reset", rdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tx_q.push_back(1'b1);
    bus_read(32'h08, 32'd0);
    bus_read(32'h0C, 32'd9600);
    bus_read(32'h10, 32'd0);
    bus_read(32'h14, 32'd1);
    bus_read(32'h00, 32'd0);

    // Soft reset mid-frame
    bus_write(32'h0C, 32'd4);
    bus_write(32'h10, 32'd1);
    bus_write(32'h14, 32'd2);
    bus_read(32'h0C, 32'd4);
    wait_tx_drain(100);
    bus_write(32'h00, 32'h3C);
    repeat (6) @(negedge clk);
    sample("tx_mid_frame_s", {31'd0, tx}, 32'd0);
    bus_write(32'h24, 32'd1);
    sample("tx_soft_reset", {31'd0, tx}, 32'd1);
    sample("rdata_soft_reset", rdata, 32'd0);
    repeat (2) tx_q.push_back(1'b1);
    bus_read(32'h08, 32'd0);
    bus_read(32'h0C, 32'd9600);
    bus_read(32'h10, 32'd0);
    bus_read(32'h14, 32'd1);
    bus_read(32'h00, 32'd0);

    // Drain and report
    wait_tx_drain(100);
    for (int i = 0; i < 50 && (exp_q.size() != 0 || dir_exp_q.size() != 0); i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) sample("read_drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
